// File: rtl/sbf_pkg.sv
// Shared flit-type constants, arbiter state type and header helpers
// for the butterfly output-port arbiter.
package sbf_pkg;

  localparam logic [1:0] HEADER_TYPE  = 2'b11;
  localparam logic [1:0] PAYLOAD_TYPE = 2'b10;
  localparam logic [1:0] NULL_TYPE    = 2'b00;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic logic [1:0] hdr_type(input logic [3:0] nibble);
    return nibble[3:2];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set req bit at or after ptr.
module rr_pick #(
  parameter  int PORTS = 4,
  localparam int ADR_W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [ADR_W-1:0] ptr,
  output logic             found,
  output logic [ADR_W-1:0] idx,
  output logic [PORTS-1:0] onehot
);

  logic [ADR_W-1:0] cand;

  // Scan from farthest to nearest so the nearest requester is written last.
  // PORTS is a power of two, so ADR_W-bit addition wraps modulo PORTS.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      cand = ptr + ADR_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Packet-aware round-robin allocator for one butterfly output port:
// grants one input per packet and holds it until the payload ends.
module rr_packet_arbiter
  import sbf_pkg::*;
#(
  parameter  int PORTS = 4,
  localparam int ADR_W = $clog2(PORTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADR_W-1:0]      r_adr,
  input  logic [PORTS-1:0][3:0] in_ch_hdr_msn,
  input  logic                  out_ready,
  output logic [PORTS-1:0]      sel,
  output logic                  shift,
  output logic                  busy,
  output logic [ADR_W-1:0]      owner
);

  arb_state_t       state, state_n;
  logic [ADR_W-1:0] ptr, ptr_n, owner_n;
  logic [PORTS-1:0] req, pick_onehot;
  logic             pick_found;
  logic [ADR_W-1:0] pick_idx;
  logic             owner_payload;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      req[i] = (hdr_type(in_ch_hdr_msn[i]) == HEADER_TYPE) &&
               (in_ch_hdr_msn[i][ADR_W-1:0] == r_adr);
    end
  end

  rr_pick #(.PORTS(PORTS)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign owner_payload = (hdr_type(in_ch_hdr_msn[owner]) == PAYLOAD_TYPE);

  // A locked owner showing anything but payload releases the port in the
  // same cycle, and arbitration reruns so back-to-back packets need no bubble.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    sel     = '0;
    shift   = 1'b0;
    if (rst) begin
      state_n = IDLE;
    end else if (state == LOCKED && owner_payload) begin
      sel[owner] = 1'b1;
      shift      = out_ready;
    end else if (pick_found && out_ready) begin
      sel     = pick_onehot;
      shift   = 1'b1;
      state_n = LOCKED;
      owner_n = pick_idx;
      ptr_n   = pick_idx + ADR_W'(1);
    end else begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
    end
  end

  assign busy = (state == LOCKED);

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter (PORTS=4): reset, single packet,
// fairness, backpressure, back-to-back and ignored-header scenarios.
module tb_rr_packet_arbiter;

  logic            clk;
  logic            rst;
  logic [1:0]      r_adr;
  logic [3:0][3:0] hdr;
  logic            out_ready;
  logic [3:0]      sel;
  logic            shift;
  logic            busy;
  logic [1:0]      owner;

  int total = 0;
  int bad   = 0;

  rr_packet_arbiter #(.PORTS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .r_adr         (r_adr),
    .in_ch_hdr_msn (hdr),
    .out_ready     (out_ready),
    .sel           (sel),
    .shift         (shift),
    .busy          (busy),
    .owner         (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hdr = '0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r_adr = 2'd0;
    out_ready = 1'b1;
    hdr = '0;
    hdr[0] = 4'b1100;
    @(negedge clk);
    total++; if (sel !== 4'b0000) begin bad++; $display("FAIL rst_sel got=%b exp=0000", sel); end
    total++; if (shift !== 1'b0) begin bad++; $display("FAIL rst_shift got=%b exp=0", shift); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tick();
    rst = 1'b0;
    hdr = '0;
    hdr[2] = 4'b1100;
    @(negedge clk);
    total++; if (sel !== 4'b0100) begin bad++; $display("FAIL rst_grant2 sel got=%b exp=0100", sel); end
    tick();
    hdr[2] = 4'b1000;
    @(negedge clk);
    total++; if (busy !== 1'b1 || owner !== 2'd2) begin bad++; $display("FAIL rst_locked busy/owner got=%b/%0d exp=1/2", busy, owner); end
    #2 rst = 1'b1;
    #1;
    total++; if (sel !== 4'b0000 || shift !== 1'b0) begin bad++; $display("FAIL rst_mid sel/shift got=%b/%b exp=0000/0", sel, shift); end
    total++; if (busy !== 1'b0 || owner !== 2'd0) begin bad++; $display("FAIL rst_mid busy/owner got=%b/%0d exp=0/0", busy, owner); end
    tick();
    rst = 1'b0;
    hdr = {4'b1100, 4'b1100, 4'b1100, 4'b1100};
    @(negedge clk);
    total++; if (sel !== 4'b0001) begin bad++; $display("FAIL rst_ptr0 sel got=%b exp=0001", sel); end
    tick();
  endtask

  task automatic test_single_packet();
    logic [3:0] seq [4];
    logic [3:0] exp_sel [4];
    logic       exp_shift [4];
    seq       = '{4'b1101, 4'b1000, 4'b1000, 4'b0000};
    exp_sel   = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
    exp_shift = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    r_adr = 2'd1;
    for (int c = 0; c < 4; c++) begin
      hdr[0] = seq[c];
      @(negedge clk);
      total++; if (sel !== exp_sel[c] || shift !== exp_shift[c]) begin bad++; $display("FAIL single_c%0d sel/shift got=%b/%b exp=%b/%b", c, sel, shift, exp_sel[c], exp_shift[c]); end
      if (c > 0) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_c%0d got=%b exp=1", c, busy); end
      end
      tick();
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_release busy got=%b exp=0", busy); end
    tick();
  endtask

  task automatic test_fairness();
    int order [5];
    logic [3:0] exp;
    order = '{0, 1, 2, 3, 0};
    do_reset();
    r_adr = 2'd0;
    hdr = {4'b1100, 4'b1100, 4'b1100, 4'b1100};
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << order[g];
      @(negedge clk);
      total++; if (sel !== exp || shift !== 1'b1) begin bad++; $display("FAIL fair_grant%0d sel/shift got=%b/%b exp=%b/1", g, sel, shift, exp); end
      tick();
      hdr[order[g]] = 4'b1000;
      @(negedge clk);
      total++; if (sel !== exp || owner !== 2'(order[g]) || busy !== 1'b1) begin bad++; $display("FAIL fair_payload%0d sel/owner/busy got=%b/%0d/%b exp=%b/%0d/1", g, sel, owner, busy, exp, order[g]); end
      tick();
      hdr[order[g]] = 4'b1100;
    end
    hdr = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    r_adr = 2'd0;
    hdr[1] = 4'b1100;
    out_ready = 1'b0;
    @(negedge clk);
    total++; if (sel !== 4'b0000 || shift !== 1'b0) begin bad++; $display("FAIL bp_idle_stall sel/shift got=%b/%b exp=0000/0", sel, shift); end
    tick();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle_busy got=%b exp=0", busy); end
    out_ready = 1'b1;
    tick();
    hdr[1] = 4'b1000;
    hdr[0] = 4'b1100;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (sel !== 4'b0010 || shift !== 1'b0 || owner !== 2'd1 || busy !== 1'b1) begin bad++; $display("FAIL bp_stall%0d sel/shift/owner/busy got=%b/%b/%0d/%b exp=0010/0/1/1", c, sel, shift, owner, busy); end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (sel !== 4'b0010 || shift !== 1'b1) begin bad++; $display("FAIL bp_resume sel/shift got=%b/%b exp=0010/1", sel, shift); end
    tick();
    hdr[1] = 4'b0000;
    hdr[2] = 4'b1100;
    @(negedge clk);
    total++; if (sel !== 4'b0100) begin bad++; $display("FAIL bp_ptr sel got=%b exp=0100", sel); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    r_adr = 2'd0;
    hdr[1] = 4'b1100;
    tick();
    hdr[1] = 4'b1000;
    @(negedge clk);
    total++; if (sel !== 4'b0010) begin bad++; $display("FAIL b2b_payload sel got=%b exp=0010", sel); end
    tick();
    hdr[1] = 4'b0000;
    hdr[3] = 4'b1100;
    @(negedge clk);
    total++; if (sel !== 4'b1000 || shift !== 1'b1) begin bad++; $display("FAIL b2b_switch sel/shift got=%b/%b exp=1000/1", sel, shift); end
    tick();
    hdr[3] = 4'b1000;
    @(negedge clk);
    total++; if (owner !== 2'd3 || busy !== 1'b1 || sel !== 4'b1000) begin bad++; $display("FAIL b2b_owner owner/busy/sel got=%0d/%b/%b exp=3/1/1000", owner, busy, sel); end
    tick();
    hdr[3] = 4'b0000;
    hdr[0] = 4'b1100;
    hdr[1] = 4'b1100;
    @(negedge clk);
    total++; if (sel !== 4'b0001) begin bad++; $display("FAIL b2b_ptr sel got=%b exp=0001", sel); end
    tick();
  endtask

  task automatic test_ignored_headers();
    do_reset();
    r_adr = 2'd1;
    hdr[2] = 4'b1110;
    hdr[3] = 4'b1001;
    @(negedge clk);
    total++; if (sel !== 4'b0000 || shift !== 1'b0) begin bad++; $display("FAIL nomatch sel/shift got=%b/%b exp=0000/0", sel, shift); end
    tick();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL nomatch_busy got=%b exp=0", busy); end
    tick();
    hdr = '0;
    hdr[0] = 4'b1101;
    tick();
    hdr[0] = 4'b1000;
    hdr[2] = 4'b1101;
    hdr[3] = 4'b1001;
    @(negedge clk);
    total++; if (sel !== 4'b0001 || owner !== 2'd0) begin bad++; $display("FAIL held_off sel/owner got=%b/%0d exp=0001/0", sel, owner); end
    tick();
    hdr[0] = 4'b0000;
    @(negedge clk);
    total++; if (sel !== 4'b0100 || shift !== 1'b1) begin bad++; $display("FAIL held_grant sel/shift got=%b/%b exp=0100/1", sel, shift); end
    tick();
    hdr[2] = 4'b1000;
    @(negedge clk);
    total++; if (owner !== 2'd2) begin bad++; $display("FAIL held_owner got=%0d exp=2", owner); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    r_adr = '0;
    hdr = '0;
    out_ready = 1'b1;
    test_reset();
    test_single_packet();
    test_fairness();
    test_backpressure();
    test_back_to_back();
    test_ignored_headers();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
